// File: rtl/dmem_split_ctrl.sv
// Byte-addressable little-endian data memory with valid/ready request port,
// registered one-cycle response, misaligned split into two word beats, and fault reporting.
module dmem_split_ctrl #(
  parameter int MEM_NBYTE      = 1024,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // state | meaning
  // IDLE  | ready; aligned/fault requests complete here in one edge
  // BEAT2 | second word of a split access (word w+1), not ready
  typedef enum logic {IDLE, BEAT2} state_t;

  localparam int NW = MEM_NBYTE / 4;
  localparam int AW = (NW > 1) ? $clog2(NW) : 1;

  state_t            state, state_d;
  logic [31:0]       mem [NW];

  logic [1:0]        off;
  logic [2:0]        nbytes;
  logic              crossing;
  logic [32:0]       last_addr;
  logic              fault;
  logic [AW-1:0]     idx;
  logic [31:0]       rd_word;
  logic [31:0]       rd_next;

  logic              l_we;
  logic [1:0]        l_size;
  logic              l_uns;
  logic [1:0]        l_off;
  logic [AW-1:0]     l_idx;
  logic [AW-1:0]     l_idx_next;
  logic [31:0]       l_wdata;
  logic [31:0]       l_lo;
  logic              latch_en;

  logic [1:0]        sel_off;
  logic [1:0]        sel_size;
  logic [31:0]       sel_wdata;
  logic [7:0]        lane_mask;
  logic [63:0]       lane_data;

  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;

  logic              rsp_valid_d;
  logic [31:0]       rsp_rdata_d;
  logic              rsp_err_d;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'b00:   return {{24{~uns & d[7]}}, d[7:0]};
      2'b01:   return {{16{~uns & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign req_ready = (state == IDLE);

  assign off  = req_addr[1:0];
  assign idx  = req_addr[AW+1:2];

  always_comb begin
    case (req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
  end

  // 33-bit last-byte address so accesses near 2^32 cannot wrap into range
  assign last_addr = {1'b0, req_addr} + 33'(nbytes) - 33'd1;
  assign crossing  = ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
  assign fault     = (req_size == 2'b11) || (last_addr >= 33'(MEM_NBYTE)) ||
                     (crossing && !ALLOW_MISALIGN);

  assign l_idx_next = l_idx + AW'(1);
  assign rd_word    = mem[idx];
  assign rd_next    = mem[l_idx_next];

  // One lane shifter serves both beats: low half for word w, high half for w+1
  always_comb begin
    sel_off   = (state == BEAT2) ? l_off   : off;
    sel_size  = (state == BEAT2) ? l_size  : req_size;
    sel_wdata = (state == BEAT2) ? l_wdata : req_wdata;
    lane_mask = {4'b0000, size_mask(sel_size)} << sel_off;
    lane_data = {32'h0, sel_wdata} << {sel_off, 3'b000};
  end

  always_comb begin
    state_d     = state;
    latch_en    = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = idx;
    wr_be       = 4'b0000;
    wr_data     = 32'h0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (fault) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (crossing) begin
            latch_en = 1'b1;
            state_d  = BEAT2;
            if (req_we) begin
              wr_en   = 1'b1;
              wr_be   = lane_mask[3:0];
              wr_data = lane_data[31:0];
            end
          end else begin
            rsp_valid_d = 1'b1;
            if (req_we) begin
              wr_en   = 1'b1;
              wr_be   = lane_mask[3:0];
              wr_data = lane_data[31:0];
            end else begin
              rsp_rdata_d = extend(rd_word >> {off, 3'b000}, req_size, req_unsigned);
            end
          end
        end
      end
      BEAT2: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        if (l_we) begin
          wr_en   = 1'b1;
          wr_idx  = l_idx_next;
          wr_be   = lane_mask[7:4];
          wr_data = lane_data[63:32];
        end else begin
          rsp_rdata_d = extend(32'({rd_next, l_lo} >> {l_off, 3'b000}), l_size, l_uns);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      l_we      <= 1'b0;
      l_size    <= 2'b00;
      l_uns     <= 1'b0;
      l_off     <= 2'b00;
      l_idx     <= '0;
      l_wdata   <= 32'h0;
      l_lo      <= 32'h0;
    end else begin
      state     <= state_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      if (latch_en) begin
        l_we    <= req_we;
        l_size  <= req_size;
        l_uns   <= req_unsigned;
        l_off   <= off;
        l_idx   <= idx;
        l_wdata <= req_wdata;
        l_lo    <= rd_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) mem[i] <= 32'h0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_split_ctrl.sv
// Directed bench for dmem_split_ctrl: vector table for single requests,
// hand sequences for throughput and reset during a split access.
module tb_dmem_split_ctrl;

  localparam int MEM_NBYTE = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_valid, a_ready, a_we, a_uns, a_rsp_valid, a_rsp_err;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rsp_rdata;
  logic        b_valid, b_ready, b_we, b_uns, b_rsp_valid, b_rsp_err;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rsp_rdata;

  dmem_split_ctrl #(.MEM_NBYTE(MEM_NBYTE), .ALLOW_MISALIGN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_size(a_size), .req_unsigned(a_uns), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));

  dmem_split_ctrl #(.MEM_NBYTE(MEM_NBYTE), .ALLOW_MISALIGN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_size(b_size), .req_unsigned(b_uns), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

  typedef struct {
    bit          sel;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input bit sel, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    vec_t v;
    v.sel = sel; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input bit sel, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err, output int lat,
                        output logic rdy1);
    @(negedge clk);
    if (!sel) begin
      a_valid = 1'b1; a_we = we; a_size = size; a_uns = uns; a_addr = addr; a_wdata = wdata;
    end else begin
      b_valid = 1'b1; b_we = we; b_size = size; b_uns = uns; b_addr = addr; b_wdata = wdata;
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rdy1 = sel ? b_ready : a_ready;
    lat = 1;
    while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (!(sel ? b_rsp_valid : a_rsp_valid)) lat = 99;
    rd  = sel ? b_rsp_rdata : a_rsp_rdata;
    err = sel ? b_rsp_err : a_rsp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic        rdy1;
    int          lat;
    logic        tp_we  [5];
    logic [31:0] tp_addr[5];
    logic [31:0] tp_wd  [5];
    logic [31:0] tp_exp [5];

    // ALLOW_MISALIGN=1 instance (sel 0)
    tbl.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0,       32'hDEADBEEF, 0, 1));
    tbl.push_back(mk(0, 0, 2'b00, 0, 32'h13, 32'h0,       32'hFFFFFFDE, 0, 1));
    tbl.push_back(mk(0, 0, 2'b00, 1, 32'h13, 32'h0,       32'h000000DE, 0, 1));
    tbl.push_back(mk(0, 0, 2'b01, 0, 32'h12, 32'h0,       32'hFFFFDEAD, 0, 1));
    tbl.push_back(mk(0, 0, 2'b01, 1, 32'h12, 32'h0,       32'h0000DEAD, 0, 1));
    tbl.push_back(mk(0, 0, 2'b00, 0, 32'h10, 32'h0,       32'hFFFFFFEF, 0, 1));
    tbl.push_back(mk(0, 0, 2'b01, 0, 32'h10, 32'h0,       32'hFFFFBEEF, 0, 1));
    tbl.push_back(mk(0, 1, 2'b10, 0, 32'h21, 32'h11223344, 32'h0,       0, 2));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h20, 32'h0,       32'h22334400, 0, 1));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h24, 32'h0,       32'h00000011, 0, 1));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h21, 32'h0,       32'h11223344, 0, 2));
    tbl.push_back(mk(0, 1, 2'b00, 0, 32'h24, 32'hAABBCCF0, 32'h0,       0, 1));
    tbl.push_back(mk(0, 0, 2'b01, 0, 32'h23, 32'h0,       32'hFFFFF022, 0, 2));
    tbl.push_back(mk(0, 0, 2'b01, 1, 32'h23, 32'h0,       32'h0000F022, 0, 2));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h3E, 32'h0,       32'h0,        1, 1));
    tbl.push_back(mk(0, 0, 2'b11, 0, 32'h10, 32'h0,       32'h0,        1, 1));
    tbl.push_back(mk(0, 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 32'h0,       1, 1));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0,       32'hDEADBEEF, 0, 1));
    tbl.push_back(mk(0, 1, 2'b10, 0, 32'h3E, 32'hAAAAAAAA, 32'h0,       1, 1));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h3C, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(0, 0, 2'b01, 0, 32'h3F, 32'h0,       32'h0,        1, 1));
    tbl.push_back(mk(0, 0, 2'b00, 0, 32'h3F, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(0, 1, 2'b01, 0, 32'h3E, 32'h0000ABCD, 32'h0,       0, 1));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h3C, 32'h0,       32'hABCD0000, 0, 1));
    tbl.push_back(mk(0, 1, 2'b01, 0, 32'h22, 32'h99995566, 32'h0,       0, 1));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h20, 32'h0,       32'h55664400, 0, 1));
    tbl.push_back(mk(0, 1, 2'b00, 0, 32'h11, 32'h12345677, 32'h0,       0, 1));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0,       32'hDEAD77EF, 0, 1));
    tbl.push_back(mk(0, 0, 2'b00, 0, 32'h11, 32'h0,       32'h00000077, 0, 1));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h23, 32'h0,       32'h0000F055, 0, 2));
    // ALLOW_MISALIGN=0 instance (sel 1)
    tbl.push_back(mk(1, 1, 2'b01, 0, 32'h02, 32'h00001234, 32'h0,       0, 1));
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h00, 32'h0,       32'h12340000, 0, 1));
    tbl.push_back(mk(1, 1, 2'b01, 0, 32'h03, 32'h0000BEEF, 32'h0,       1, 1));
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h00, 32'h0,       32'h12340000, 0, 1));
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h04, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h01, 32'h0,       32'h0,        1, 1));

    tp_we[0] = 1; tp_addr[0] = 32'h30; tp_wd[0] = 32'hCAFEF00D; tp_exp[0] = 32'h0;
    tp_we[1] = 0; tp_addr[1] = 32'h30; tp_wd[1] = 32'h0;        tp_exp[1] = 32'hCAFEF00D;
    tp_we[2] = 0; tp_addr[2] = 32'h10; tp_wd[2] = 32'h0;        tp_exp[2] = 32'hDEAD77EF;
    tp_we[3] = 0; tp_addr[3] = 32'h20; tp_wd[3] = 32'h0;        tp_exp[3] = 32'h55664400;
    tp_we[4] = 0; tp_addr[4] = 32'h24; tp_wd[4] = 32'h0;        tp_exp[4] = 32'h000000F0;

    a_valid = 0; a_we = 0; a_size = 0; a_uns = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_size = 0; b_uns = 0; b_addr = 0; b_wdata = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", a_rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'b0, a_rsp_err}, 32'h0);
    chk("rst_req_ready", {31'b0, a_ready}, 32'h1);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      do_req(tbl[i].sel, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
             rd, err, lat, rdy1);
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
      chk($sformatf("v%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("v%0d_ready_after_accept", i), {31'b0, rdy1},
          (tbl[i].exp_lat == 1) ? 32'h1 : 32'h0);
    end

    // back-to-back: one response per cycle, in order, store then same-address load
    @(negedge clk);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) begin
        chk($sformatf("tp%0d_valid", k - 1), {31'b0, a_rsp_valid}, 32'h1);
        chk($sformatf("tp%0d_rdata", k - 1), a_rsp_rdata, tp_exp[k-1]);
        chk($sformatf("tp%0d_ready", k - 1), {31'b0, a_ready}, 32'h1);
      end
      if (k < 5) begin
        a_valid = 1; a_we = tp_we[k]; a_size = 2'b10; a_uns = 0;
        a_addr = tp_addr[k]; a_wdata = tp_wd[k];
      end else begin
        a_valid = 0;
      end
      @(negedge clk);
    end
    chk("tp_idle_after", {31'b0, a_rsp_valid}, 32'h0);

    // reset while the split load is in its second beat
    @(negedge clk);
    a_valid = 1; a_we = 0; a_size = 2'b10; a_uns = 0; a_addr = 32'h21; a_wdata = 0;
    @(negedge clk);
    a_valid = 0;
    chk("midsplit_busy", {31'b0, a_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midsplit_rst_no_rsp", {31'b0, a_rsp_valid}, 32'h0);
    @(negedge clk);
    chk("midsplit_rst_no_rsp_later", {31'b0, a_rsp_valid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midsplit_ready_after", {31'b0, a_ready}, 32'h1);
    chk("midsplit_no_rsp_after", {31'b0, a_rsp_valid}, 32'h0);
    for (int w = 0; w < MEM_NBYTE / 4; w++) begin
      do_req(0, 0, 2'b10, 0, 32'(4 * w), 32'h0, rd, err, lat, rdy1);
      chk($sformatf("cleared_w%0d", w), rd, 32'h0);
      chk($sformatf("cleared_w%0d_lat", w), lat, 1);
    end
    do_req(1, 0, 2'b10, 0, 32'h0, 32'h0, rd, err, lat, rdy1);
    chk("cleared_b_w0", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
